id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage of the 5-stage ARM-subset pipeline, directly downstream of the fetch stage / IF-ID register.
//  Decodes cond/mode/I/opcode/S/Rn/Rd/operand fields, evaluates the condition against NZCV, and reads the register file.
//  Writes back from WB through its internal register file.
//  Owns the ID/EX pipeline register: every EX-facing output is registered; hazard-unit outputs (src1/src2/two_src) are combinational.
// PARAMETERS
//  NREGS      15  architectural registers R0..R14 (R15/PC is not stored)
//  DATA_W     32  datapath width
// PORTS
//  clk            in   1   pipeline clock, all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  flush          in   1   branch taken in EX; next ID/EX contents become NOP
//  hazard         in   1   RAW hazard from hazard unit; next ID/EX contents become bubble
//  freeze         in   1   global stall; ID/EX register and register file hold (WB write still allowed)
//  pc_in          in   32  word-indexed PC+1 from IF/ID register
//  instruction_in in   32  instruction from IF/ID register
//  sr_in          in   4   status flags {N,Z,C,V}
//  wb_en          in   1   write-back enable from WB
//  wb_dest        in   4   write-back register index
//  wb_value       in   32  write-back data
//  pc_out         out  32  registered pc_in
//  val_rn         out  32  registered Rn value
//  val_rm         out  32  registered Rm (or Rd for STR) value
//  imm_out        out  1   registered I bit
//  shift_operand  out  12  registered instruction[11:0]
//  signed_imm24   out  24  registered instruction[23:0]
//  dest           out  4   registered Rd
//  exe_cmd        out  4   registered ALU command
//  mem_r_en       out  1   registered LDR strobe
//  mem_w_en       out  1   registered STR strobe
//  wb_en_out      out  1   registered write-back request
//  s_out          out  1   registered flag-update request
//  b_out          out  1   registered branch request
//  src1           out  4   comb: Rn index
//  src2           out  4   comb: Rm (data-proc) or Rd (STR)
//  two_src        out  1   comb: ~I | STR
// BEHAVIOUR
//  Reset: all outputs 0; all R0..R14 cleared to 0.
//  Latency: one cycle from instruction_in to the registered outputs.
//  Mode 00 (data-proc) ALU commands:
//    MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100,
//    SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000.
//    CMP 1010 -> exe_cmd 0100, no writeback. TST 1000 -> exe_cmd 0110, no writeback.
//    wb_en = 1 except CMP/TST. s_out = S bit.
//  Mode 01 (memory): exe_cmd 0010. S=1 is LDR (mem_r_en=1, wb_en=1); S=0 is STR (mem_w_en=1).
//  Mode 10 (branch): b_out = 1, wb_en = 0, exe_cmd don't-care (0).
//  Condition codes 0000..1110 use standard ARM semantics on sr_in (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL); 1111 = never.
//  Cond fail: wb_en, mem_r_en, mem_w_en, s_out and b_out are latched as 0; data fields are still latched.
//  Priority each edge: rst > flush > freeze > hazard > normal.
//    flush: all controls latched 0, data fields don't-care.
//    freeze: ID/EX holds its current value.
//    hazard: controls latched 0 (bubble).
//  Register file:
//    Write at posedge when wb_en && wb_dest != 15.
//    Writes to index 15 are ignored; reads of index 15 return 0.
//    Same-cycle read of the register being written returns wb_value (write-through bypass).
//    Writes occur even when freeze or hazard is asserted.
//  Reset asserted mid-stream clears the ID/EX register and the register file in the same cycle; an in-flight WB write is dropped.
// STRUCTURE
//  Shared header arm_defs.vh holds:
//    mode encodings, opcode constants, exe_cmd constants, cond codes, NOP value.
//  Sub-module register_file: 2 read ports, 1 write port, bypass.
//  The top level holds the decode/cond logic and the ID/EX register.
// TESTING
//  1. rst=1 one cycle -> all outputs 0. Then read R0..R14 -> 0.
//  2. instr 0xE3A00014 (MOV R0,#20) -> next cycle exe_cmd=0001, dest=0, imm_out=1, wb_en_out=1, shift_operand=0x014.
//  3. wb_en=1, wb_dest=2, wb_value=0x1234 while instr is ADD R3,R2,R2.
//       -> val_rn=val_rm=0x1234 (bypass); two_src=1, src1=2, src2=2.
//  4. instr 0x0... (EQ) with sr_in Z=0 -> wb_en_out=0.
//       Same instr with Z=1 -> wb_en_out=1.
//  5. STR R1,[R0,#0] -> mem_w_en=1, src2=1, two_src=1.
//       Same cycle flush=1 -> all controls 0. hazard=1 (no flush) -> bubble.
//  6. freeze=1 for 3 cycles with changing instruction_in -> outputs unchanged.
//       wb write to R5 during freeze -> R5 updated.

Source files
------------

// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared encodings, ID/EX record and condition evaluation for the decode stage
package id_stage_pkg;

  localparam int NREGS  = 15;
  localparam int DATA_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [3:0]  PC_REG    = 4'd15;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;
  localparam logic [3:0] EXE_MVN  = 4'b1001;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm24;
    logic [3:0]        dest;
    logic [3:0]        exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic              s;
    logic              b;
  } idex_t;

  // sr is {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
    logic n, z, c, v;
    {n, z, c, v} = sr;
    case (cond_e'(cond))
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// rtl/id_stage_register_file.sv - R0..R14 register file, two read ports, one write port with write-through bypass
module id_stage_register_file
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rd_addr1,
  input  logic [3:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_ok;

  assign wr_ok = wr_en && (wr_addr != PC_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // R15 is the PC and lives outside this file, so it always reads as zero here
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_addr1 != PC_REG) rd_data1 = (wr_ok && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
    if (rd_addr2 != PC_REG) rd_data2 = (wr_ok && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode, condition check, register read and ID/EX pipeline register
module id_stage
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hazard,
  input  logic              freeze,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instruction_in,
  input  logic [3:0]        sr_in,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm_out,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm24,
  output logic [3:0]        dest,
  output logic [3:0]        exe_cmd,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en_out,
  output logic              s_out,
  output logic              b_out,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src
);

  logic [3:0]        cond;
  logic [1:0]        mode;
  logic              i_bit;
  logic [3:0]        opcode;
  logic              s_bit;
  logic [3:0]        rn;
  logic [3:0]        rd;
  logic [3:0]        rm;
  logic              is_str;
  logic [DATA_W-1:0] rf_rn;
  logic [DATA_W-1:0] rf_rm;
  idex_t             dec;
  idex_t             bubble;
  idex_t             idex_q;

  assign cond   = instruction_in[31:28];
  assign mode   = instruction_in[27:26];
  assign i_bit  = instruction_in[25];
  assign opcode = instruction_in[24:21];
  assign s_bit  = instruction_in[20];
  assign rn     = instruction_in[19:16];
  assign rd     = instruction_in[15:12];
  assign rm     = instruction_in[3:0];

  assign is_str  = (mode_e'(mode) == MODE_MEM) && !s_bit;
  assign src1    = rn;
  assign src2    = is_str ? rd : rm;
  assign two_src = !i_bit || is_str;

  id_stage_register_file u_rf (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (src1),
    .rd_addr2 (src2),
    .rd_data1 (rf_rn),
    .rd_data2 (rf_rm),
    .wr_en    (wb_en),
    .wr_addr  (wb_dest),
    .wr_data  (wb_value)
  );

  always_comb begin
    dec               = '0;
    dec.pc            = pc_in;
    dec.val_rn        = rf_rn;
    dec.val_rm        = rf_rm;
    dec.imm           = i_bit;
    dec.shift_operand = instruction_in[11:0];
    dec.signed_imm24  = instruction_in[23:0];
    dec.dest          = rd;

    case (mode_e'(mode))
      MODE_DP: begin
        dec.wb_en = 1'b1;
        dec.s     = s_bit;
        case (opcode)
          OP_MOV:  dec.exe_cmd = EXE_MOV;
          OP_MVN:  dec.exe_cmd = EXE_MVN;
          OP_ADD:  dec.exe_cmd = EXE_ADD;
          OP_ADC:  dec.exe_cmd = EXE_ADC;
          OP_SUB:  dec.exe_cmd = EXE_SUB;
          OP_SBC:  dec.exe_cmd = EXE_SBC;
          OP_AND:  dec.exe_cmd = EXE_AND;
          OP_ORR:  dec.exe_cmd = EXE_ORR;
          OP_EOR:  dec.exe_cmd = EXE_EOR;
          OP_CMP: begin
            dec.exe_cmd = EXE_SUB;
            dec.wb_en   = 1'b0;
          end
          OP_TST: begin
            dec.exe_cmd = EXE_AND;
            dec.wb_en   = 1'b0;
          end
          default: dec.exe_cmd = EXE_NONE;
        endcase
      end
      MODE_MEM: begin
        dec.exe_cmd  = EXE_ADD;
        dec.mem_r_en = s_bit;
        dec.wb_en    = s_bit;
        dec.mem_w_en = !s_bit;
      end
      MODE_BR: dec.b = 1'b1;
      default: ;
    endcase

    // a failed condition squashes side effects but keeps the ALU command and data
    if (!cond_pass(cond, sr_in)) begin
      dec.mem_r_en = 1'b0;
      dec.mem_w_en = 1'b0;
      dec.wb_en    = 1'b0;
      dec.s        = 1'b0;
      dec.b        = 1'b0;
    end

    bubble          = dec;
    bubble.exe_cmd  = EXE_NONE;
    bubble.mem_r_en = 1'b0;
    bubble.mem_w_en = 1'b0;
    bubble.wb_en    = 1'b0;
    bubble.s        = 1'b0;
    bubble.b        = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)          idex_q <= '0;
    else if (flush)   idex_q <= bubble;
    else if (!freeze) idex_q <= hazard ? bubble : dec;
  end

  assign pc_out        = idex_q.pc;
  assign val_rn        = idex_q.val_rn;
  assign val_rm        = idex_q.val_rm;
  assign imm_out       = idex_q.imm;
  assign shift_operand = idex_q.shift_operand;
  assign signed_imm24  = idex_q.signed_imm24;
  assign dest          = idex_q.dest;
  assign exe_cmd       = idex_q.exe_cmd;
  assign mem_r_en      = idex_q.mem_r_en;
  assign mem_w_en      = idex_q.mem_w_en;
  assign wb_en_out     = idex_q.wb_en;
  assign s_out         = idex_q.s;
  assign b_out         = idex_q.b;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, hazard, freeze;
  logic [31:0] pc_in, instruction_in, wb_value;
  logic [3:0]  sr_in, wb_dest;
  logic        wb_en;
  logic [31:0] pc_out, val_rn, val_rm;
  logic        imm_out;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm24;
  logic [3:0]  dest, exe_cmd, src1, src2;
  logic        mem_r_en, mem_w_en, wb_en_out, s_out, b_out, two_src;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .hazard(hazard), .freeze(freeze),
    .pc_in(pc_in), .instruction_in(instruction_in), .sr_in(sr_in),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm), .imm_out(imm_out),
    .shift_operand(shift_operand), .signed_imm24(signed_imm24), .dest(dest),
    .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_en_out(wb_en_out), .s_out(s_out), .b_out(b_out),
    .src1(src1), .src2(src2), .two_src(two_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // controls packed as {exe_cmd, mem_r, mem_w, wb, s, b}
  function automatic logic [31:0] ctrl();
    return {23'd0, exe_cmd, mem_r_en, mem_w_en, wb_en_out, s_out, b_out};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; hazard = 1'b0; freeze = 1'b0;
    pc_in = 32'h0000_0044; instruction_in = 32'hE3A00014; sr_in = 4'h0;
    wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'h0;

    // reset
    tick();
    chk("rst_ctrl", ctrl(), 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_data", {val_rn | val_rm, 8'd0, signed_imm24}, 32'h0);
    chk("rst_misc", {19'd0, imm_out, shift_operand}, 32'h0);
    chk("rst_dest", {28'd0, dest}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      instruction_in = 32'hE0800000 | (i << 16) | i;
      tick();
      chk($sformatf("rst_reg_R%0d", i), val_rn | val_rm, 32'h0);
    end

    // MOV R0,#20
    pc_in = 32'h0000_0010; instruction_in = 32'hE3A00014;
    tick();
    chk("mov_ctrl", ctrl(), {23'd0, 4'b0001, 5'b00100});
    chk("mov_dest", {28'd0, dest}, 32'd0);
    chk("mov_imm", {31'd0, imm_out}, 32'd1);
    chk("mov_shift", {20'd0, shift_operand}, 32'h014);
    chk("mov_imm24", {8'd0, signed_imm24}, 32'hA00014);
    chk("mov_pc", pc_out, 32'h10);

    // ADD R3,R2,R2 with WB writing R2 the same cycle
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h1234; instruction_in = 32'hE0823002;
    #1;
    chk("add_src", {24'd0, src1, src2}, 32'h22);
    chk("add_two_src", {31'd0, two_src}, 32'd1);
    tick();
    chk("add_bypass_rn", val_rn, 32'h1234);
    chk("add_bypass_rm", val_rm, 32'h1234);
    chk("add_ctrl", ctrl(), {23'd0, 4'b0010, 5'b00100});
    chk("add_dest", {28'd0, dest}, 32'd3);
    wb_en = 1'b0;

    // condition codes
    instruction_in = 32'h00823002; sr_in = 4'b0000;
    tick();
    chk("eq_fail_ctrl", ctrl(), {23'd0, 4'b0010, 5'b00000});
    chk("eq_fail_rn", val_rn, 32'h1234);
    sr_in = 4'b0100;
    tick();
    chk("eq_pass_wb", {31'd0, wb_en_out}, 32'd1);
    instruction_in = 32'hC0823002; sr_in = 4'b1001;
    tick();
    chk("gt_pass_wb", {31'd0, wb_en_out}, 32'd1);
    instruction_in = 32'hB0823002;
    tick();
    chk("lt_fail_wb", {31'd0, wb_en_out}, 32'd0);
    instruction_in = 32'h80823002; sr_in = 4'b0010;
    tick();
    chk("hi_pass_wb", {31'd0, wb_en_out}, 32'd1);
    instruction_in = 32'h90823002;
    tick();
    chk("ls_fail_wb", {31'd0, wb_en_out}, 32'd0);
    instruction_in = 32'hF3A00014; sr_in = 4'b1111;
    tick();
    chk("nv_fail_ctrl", ctrl(), {23'd0, 4'b0001, 5'b00000});
    sr_in = 4'b0000;

    // STR R1,[R0,#0], then flush and hazard on the same instruction
    instruction_in = 32'hE5801000;
    #1;
    chk("str_src", {24'd0, src1, src2}, 32'h01);
    chk("str_two_src", {31'd0, two_src}, 32'd1);
    tick();
    chk("str_ctrl", ctrl(), {23'd0, 4'b0010, 5'b01000});
    flush = 1'b1;
    tick();
    chk("flush_ctrl", ctrl(), 32'h0);
    flush = 1'b0; hazard = 1'b1;
    tick();
    chk("hazard_ctrl", ctrl(), 32'h0);
    chk("hazard_dest", {28'd0, dest}, 32'd1);
    hazard = 1'b0;

    // other decodes
    instruction_in = 32'hE5901000;
    tick();
    chk("ldr_ctrl", ctrl(), {23'd0, 4'b0010, 5'b10100});
    instruction_in = 32'hE3520005;
    #1;
    chk("cmp_two_src", {31'd0, two_src}, 32'd0);
    tick();
    chk("cmp_ctrl", ctrl(), {23'd0, 4'b0100, 5'b00010});
    instruction_in = 32'hE3120005;
    tick();
    chk("tst_ctrl", ctrl(), {23'd0, 4'b0110, 5'b00010});
    instruction_in = 32'hE3E01000;
    tick();
    chk("mvn_ctrl", ctrl(), {23'd0, 4'b1001, 5'b00100});
    instruction_in = 32'hE0D21002;
    tick();
    chk("sbc_ctrl", ctrl(), {23'd0, 4'b0101, 5'b00110});
    instruction_in = 32'hE2221001;
    tick();
    chk("eor_ctrl", ctrl(), {23'd0, 4'b1000, 5'b00100});
    instruction_in = 32'hEA000010;
    tick();
    chk("b_ctrl", ctrl(), {23'd0, 4'b0000, 5'b00001});
    chk("b_imm24", {8'd0, signed_imm24}, 32'h000010);

    // freeze holds ID/EX while the register file still accepts a write
    pc_in = 32'h20; instruction_in = 32'hE3A00014;
    tick();
    freeze = 1'b1; wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'hABCD;
    pc_in = 32'h24; instruction_in = 32'hEA000010;
    tick();
    wb_en = 1'b0;
    chk("frz1_ctrl", ctrl(), {23'd0, 4'b0001, 5'b00100});
    instruction_in = 32'hE5801000; hazard = 1'b1;
    tick();
    chk("frz2_ctrl", ctrl(), {23'd0, 4'b0001, 5'b00100});
    hazard = 1'b0; instruction_in = 32'hE3520005;
    tick();
    chk("frz3_ctrl", ctrl(), {23'd0, 4'b0001, 5'b00100});
    chk("frz3_shift", {20'd0, shift_operand}, 32'h014);
    chk("frz3_pc", pc_out, 32'h20);
    flush = 1'b1;
    tick();
    chk("flush_over_freeze", ctrl(), 32'h0);
    flush = 1'b0; freeze = 1'b0;
    instruction_in = 32'hE0856005;
    tick();
    chk("frz_wb_R5", val_rn, 32'hABCD);

    // R15 is neither written nor read back
    wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'hDEAD; instruction_in = 32'hE08F000F;
    tick();
    chk("r15_read", val_rn | val_rm, 32'h0);
    wb_en = 1'b0;

    // reset mid-stream drops the WB write and clears the file
    instruction_in = 32'hE3A00014; wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h77; rst = 1'b1;
    tick();
    chk("midrst_ctrl", ctrl(), 32'h0);
    chk("midrst_pc", pc_out, 32'h0);
    rst = 1'b0; wb_en = 1'b0; instruction_in = 32'hE0870002;
    tick();
    chk("midrst_R7", val_rn, 32'h0);
    chk("midrst_R2", val_rm, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
